// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: single-outstanding controller between the cache stage and an external async SRAM.
// Reads fetch an aligned line of BURST_LEN words; writes store one 32-bit word as 32/DQ_W beats.
module sram_burst_ctrl #(
  parameter int          ADDR_W      = 18,
  parameter int          DQ_W        = 16,
  parameter int          BURST_LEN   = 4,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MEM_R_EN,
  input  logic                      MEM_W_EN,
  input  logic [31:0]               Data_address,
  input  logic [31:0]               Data_in,
  output logic [DQ_W*BURST_LEN-1:0] Data_out,
  output logic                      ready,
  output logic                      err,
  output logic                      freeze_signal,
  output logic [ADDR_W-1:0]         SRAM_ADDR,
  inout  wire  [DQ_W-1:0]           SRAM_DQ,
  output logic                      SRAM_UB_N,
  output logic                      SRAM_LB_N,
  output logic                      SRAM_WE_N,
  output logic                      SRAM_CE_N,
  output logic                      SRAM_OE_N
);

  localparam int LINE_W   = DQ_W * BURST_LEN;
  localparam int WR_BEATS = 32 / DQ_W;
  localparam int SHIFT    = $clog2(DQ_W / 8);

  localparam logic [ADDR_W-1:0] RD_MASK   = ADDR_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] WR_MASK   = ADDR_W'(WR_BEATS - 1);
  localparam logic [4:0]        RD_LAST   = 5'(BURST_LEN - 1);
  localparam logic [4:0]        WR_LAST   = 5'(WR_BEATS - 1);
  localparam logic [2:0]        WAIT_LAST = 3'(WAIT_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] word_lat;
  logic [31:0]       data_lat;
  logic [4:0]        beat;
  logic [2:0]        wait_cnt;
  logic [LINE_W-1:0] line;
  logic [LINE_W-1:0] line_next;
  logic [DQ_W-1:0]   dq_out;
  logic [DQ_W-1:0]   wr_next;
  logic              dq_oe;
  logic [31:0]       off;
  logic [31:0]       word;
  logic              out_of_range;
  logic              beat_end;
  logic [31:0]       rd_shift;
  logic [31:0]       wr_shift;

  // Keeps the line or word aligned: the low address bits come from the beat counter.
  function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] w,
                                                  input logic [4:0]        b,
                                                  input logic [ADDR_W-1:0] mask);
    return (w & ~mask) | (ADDR_W'(b) & mask);
  endfunction

  always_comb begin
    off          = Data_address - BASE_ADDR;
    word         = off >> SHIFT;
    out_of_range = (Data_address < BASE_ADDR) || ((word >> ADDR_W) != 32'd0);
    beat_end     = (wait_cnt == WAIT_LAST);
    rd_shift     = 32'(beat) * 32'(DQ_W);
    wr_shift     = (32'(beat) + 32'd1) * 32'(DQ_W);
    line_next    = (line & ~(LINE_W'({DQ_W{1'b1}}) << rd_shift)) | (LINE_W'(SRAM_DQ) << rd_shift);
    wr_next      = DQ_W'(data_lat >> wr_shift);
  end

  assign SRAM_DQ       = dq_oe ? dq_out : {DQ_W{1'bz}};
  assign freeze_signal = (MEM_R_EN | MEM_W_EN) & ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
      Data_out  <= '0;
      line      <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      beat      <= '0;
      wait_cnt  <= '0;
      word_lat  <= '0;
      data_lat  <= '0;
    end else begin
      ready     <= 1'b0;
      err       <= 1'b0;
      SRAM_UB_N <= 1'b0;
      SRAM_LB_N <= 1'b0;
      case (state)
        IDLE: begin
          if (MEM_R_EN || MEM_W_EN) begin
            word_lat <= word[ADDR_W-1:0];
            data_lat <= Data_in;
            beat     <= '0;
            wait_cnt <= '0;
            if (out_of_range) begin
              state <= DONE;
              ready <= 1'b1;
              err   <= 1'b1;
            end else if (MEM_R_EN) begin
              state     <= RD;
              SRAM_ADDR <= lane_addr(word[ADDR_W-1:0], 5'd0, RD_MASK);
              SRAM_CE_N <= 1'b0;
              SRAM_OE_N <= 1'b0;
            end else begin
              state     <= WR;
              SRAM_ADDR <= lane_addr(word[ADDR_W-1:0], 5'd0, WR_MASK);
              SRAM_CE_N <= 1'b0;
              SRAM_WE_N <= 1'b0;
              dq_out    <= Data_in[DQ_W-1:0];
              dq_oe     <= 1'b1;
            end
          end
        end
        RD: begin
          if (!beat_end) begin
            wait_cnt <= wait_cnt + 3'd1;
          end else begin
            wait_cnt <= '0;
            line     <= line_next;
            if (beat == RD_LAST) begin
              state     <= DONE;
              ready     <= 1'b1;
              Data_out  <= line_next;
              SRAM_CE_N <= 1'b1;
              SRAM_OE_N <= 1'b1;
            end else begin
              beat      <= beat + 5'd1;
              SRAM_ADDR <= lane_addr(word_lat, beat + 5'd1, RD_MASK);
            end
          end
        end
        // WE_N and the data bus are released in the same update that ends the last beat.
        WR: begin
          if (!beat_end) begin
            wait_cnt <= wait_cnt + 3'd1;
          end else begin
            wait_cnt <= '0;
            if (beat == WR_LAST) begin
              state     <= DONE;
              ready     <= 1'b1;
              SRAM_CE_N <= 1'b1;
              SRAM_WE_N <= 1'b1;
              dq_oe     <= 1'b0;
            end else begin
              beat      <= beat + 5'd1;
              SRAM_ADDR <= lane_addr(word_lat, beat + 5'd1, WR_MASK);
              dq_out    <= wr_next;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
